fetch_steer_ctrl: RTL and testbench
===================================

Name: fetch_steer_ctrl

Overview:
Owns the fetch PC and sequences the instruction-fetch stage.
- Predicts taken branches with a direct-mapped table of 2-bit saturating counters plus a branch target buffer (BTB).
- Applies redirects on mispredictions resolved in execute, holds on stall, and stops fetch past the end of instruction memory.
- Drives the fetch stage's pc, and exposes predict_taken/predict_target so downstream stages can carry the prediction.

Parameters:
IDX_BITS, 4, table index width; 2**IDX_BITS counter/BTB entries, indexed by pc[IDX_BITS+1:2]
PC_LIMIT, 128, first byte address past instruction memory (32 words)
RESET_PC, 0, pc value after reset

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
stall  in  1  hold pc (downstream not ready)
pc  out  32  current fetch address (registered)
fetch_valid  out  1  pc is a real fetch this cycle
predict_taken  out  1  prediction for instruction at pc
predict_target  out  32  predicted target when predict_taken=1, else pc+4
resolve_valid  in  1  execute stage resolving a branch this cycle
resolve_pc  in  32  address of the resolved branch
resolve_taken  in  1  actual direction
resolve_target  in  32  actual taken target
resolve_pred_taken  in  1  direction originally predicted for it
resolve_pred_target  in  32  target originally predicted for it
flush  out  1  kill younger in-flight instructions (combinational, this cycle)
halted  out  1  state==HALT

Behaviour:
- State machine RUN / FLUSH / HALT. Reset gives RUN.
- Reset values: pc=RESET_PC; all counters=2'b01 (weakly not-taken); all BTB valid=0; flush=0; halted=0.
- Lookup (combinational from pc): hit = btb_valid[idx] && btb_tag[idx]==pc.
  - predict_taken = hit && ctr[idx][1].
  - predict_target = predict_taken ? btb_target[idx] : pc+4 (32-bit wrap).
- fetch_valid = (state==RUN) && !stall && (pc < PC_LIMIT).
- Mispredict = resolve_valid && ((resolve_taken != resolve_pred_taken) || (resolve_taken && resolve_pred_target != resolve_target)).
- flush = mispredict. It is asserted in the same cycle, in any state.
- Next-pc priority, highest first:
  1. reset
  2. mispredict: pc <= resolve_taken ? resolve_target : resolve_pc+4
  3. stall or state!=RUN: hold
  4. predict_taken: pc <= btb_target[idx]
  5. pc <= pc+4
- Transitions:
  - Any state with mispredict goes to FLUSH.
  - FLUSH goes to RUN after exactly one cycle with no mispredict. fetch_valid=0 during FLUSH, giving one bubble.
  - RUN with pc >= PC_LIMIT and no mispredict goes to HALT. pc holds.
  - HALT is left only via mispredict (to FLUSH) or reset.
- Table update on every resolve_valid, regardless of state or stall:
  - ctr[ridx] saturates: +1 if resolve_taken (max 2'b11), -1 otherwise (min 2'b00).
  - If resolve_taken, also write btb_valid=1, btb_tag=resolve_pc, btb_target=resolve_target.
  - Not-taken resolves never clear a BTB entry.
- Same-cycle lookup and update to the same index: the lookup sees the old contents (write takes effect next cycle).
- Mispredict and stall in the same cycle: the redirect wins and pc updates.
- Reset asserted mid-FLUSH or mid-HALT returns everything to reset values next edge. Table contents are reinitialised.

Decomposition:
- Shared package holds the state enum (RUN/FLUSH/HALT), the counter-encoding constants (SNT=00, WNT=01, WT=10, ST=11) and the ctr_inc/ctr_dec saturating functions.
- One sub-module, bp_table: counter array + BTB, one combinational read port and one synchronous write port, parameterised by IDX_BITS.

Test Plan:
1. Reset, no resolves, no stall -> pc 0,4,8,...,124, then 128 with halted=1; fetch_valid=0 at pc=128.
2. Resolve pc=8, taken, target=0x20, pred_taken=0 -> flush=1 that cycle; next pc=0x20; one cycle with fetch_valid=0, then RUN; ctr[2]=10, BTB[2] valid with target 0x20.
3. After test 2, fetch reaches pc=8 -> predict_taken=1, predict_target=0x20, and next pc=0x20 with no flush.
4. Resolve pc=8 not-taken four times -> ctr[2] goes 10,01,00,00 (saturates); predict_taken=0 at pc=8 with the BTB entry still valid.
5. stall=1 for 3 cycles at pc=0x10 -> pc holds 0x10 and fetch_valid=0. Then raise stall plus a mispredicting resolve (pc=4, not-taken, pred_taken=1) -> pc=8 next cycle, flush=1.
6. In HALT at pc=128, mispredict resolve (pc=0x40, taken, target=0x0, pred_taken=0) -> FLUSH, then RUN from pc=0. Also assert reset during FLUSH -> pc=0, counters=01, BTB empty.

Source files
------------

// File: rtl/fetch_steer_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_steer_ctrl_pkg
// Description : Shared types and helpers for the fetch steering controller:
//               fetch FSM state encoding, 2-bit branch counter encodings
//               and saturating counter update functions.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_steer_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  localparam logic [1:0] C_CTR_SNT = 2'b00;  // strongly not-taken
  localparam logic [1:0] C_CTR_WNT = 2'b01;  // weakly not-taken
  localparam logic [1:0] C_CTR_WT  = 2'b10;  // weakly taken
  localparam logic [1:0] C_CTR_ST  = 2'b11;  // strongly taken

  function automatic logic [1:0] ctr_inc(input logic [1:0] ctr);
    return (ctr == C_CTR_ST) ? C_CTR_ST : ctr + 2'b01;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] ctr);
    return (ctr == C_CTR_SNT) ? C_CTR_SNT : ctr - 2'b01;
  endfunction

endpackage : fetch_steer_ctrl_pkg
`default_nettype wire

// File: rtl/fetch_steer_ctrl_bp_table.sv
`default_nettype none
// ============================================================================
// Module      : fetch_steer_ctrl_bp_table
// Description : Direct-mapped branch prediction table: one 2-bit saturating
//               counter plus one BTB entry (valid, full-pc tag, target) per
//               index. Combinational read port, synchronous write port.
// Revision    : 1.0 - initial release
// Ports       : clk, rst           - clock, synchronous active-high reset
//               i_rd_idx           - lookup index
//               o_rd_ctr/valid/tag/target - entry contents at i_rd_idx
//               i_wr_en, i_wr_idx  - update strobe and index
//               i_wr_taken         - resolved direction (inc/dec counter)
//               i_wr_tag/target    - BTB contents written on taken updates
// ============================================================================
module fetch_steer_ctrl_bp_table
  import fetch_steer_ctrl_pkg::*;
#(
  parameter int IDX_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_BITS-1:0] i_rd_idx,
  output logic [1:0]          o_rd_ctr,
  output logic                o_rd_valid,
  output logic [31:0]         o_rd_tag,
  output logic [31:0]         o_rd_target,
  input  logic                i_wr_en,
  input  logic [IDX_BITS-1:0] i_wr_idx,
  input  logic                i_wr_taken,
  input  logic [31:0]         i_wr_tag,
  input  logic [31:0]         i_wr_target
);

  localparam int C_ENTRIES = 2 ** IDX_BITS;

  logic [1:0]  r_ctr    [C_ENTRIES];
  logic        r_valid  [C_ENTRIES];
  logic [31:0] r_tag    [C_ENTRIES];
  logic [31:0] r_target [C_ENTRIES];

  // Reads see the pre-write contents; a same-cycle update lands next cycle.
  assign o_rd_ctr    = r_ctr[i_rd_idx];
  assign o_rd_valid  = r_valid[i_rd_idx];
  assign o_rd_tag    = r_tag[i_rd_idx];
  assign o_rd_target = r_target[i_rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < C_ENTRIES; i++) begin
        r_ctr[i]    <= C_CTR_WNT;
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
      end
    end else if (i_wr_en) begin
      r_ctr[i_wr_idx] <= i_wr_taken ? ctr_inc(r_ctr[i_wr_idx]) : ctr_dec(r_ctr[i_wr_idx]);
      // Not-taken outcomes only train the counter; the BTB entry is kept.
      if (i_wr_taken) begin
        r_valid[i_wr_idx]  <= 1'b1;
        r_tag[i_wr_idx]    <= i_wr_tag;
        r_target[i_wr_idx] <= i_wr_target;
      end
    end
  end

endmodule : fetch_steer_ctrl_bp_table
`default_nettype wire

// File: rtl/fetch_steer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_steer_ctrl
// Description : Owns the fetch PC. Predicts taken branches through a counter
//               table + BTB, redirects on execute-stage mispredicts (with a
//               one-cycle FLUSH bubble), holds on stall and halts once the
//               pc leaves instruction memory.
// Revision    : 1.0 - initial release
// Ports       : clk, reset        - clock, synchronous active-high reset
//               stall             - hold pc
//               pc, fetch_valid   - fetch address and its qualifier
//               predict_taken/target - prediction for the instruction at pc
//               resolve_*         - branch resolution from execute
//               flush             - same-cycle mispredict kill
//               halted            - controller is in HALT
// ============================================================================
module fetch_steer_ctrl
  import fetch_steer_ctrl_pkg::*;
#(
  parameter int          IDX_BITS = 4,
  parameter logic [31:0] PC_LIMIT = 32'd128,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  output logic [31:0] pc,
  output logic        fetch_valid,
  output logic        predict_taken,
  output logic [31:0] predict_target,
  input  logic        resolve_valid,
  input  logic [31:0] resolve_pc,
  input  logic        resolve_taken,
  input  logic [31:0] resolve_target,
  input  logic        resolve_pred_taken,
  input  logic [31:0] resolve_pred_target,
  output logic        flush,
  output logic        halted
);

  state_t              r_state;
  logic [31:0]         r_pc;
  logic [IDX_BITS-1:0] w_idx;
  logic [IDX_BITS-1:0] w_ridx;
  logic [1:0]          w_rd_ctr;
  logic                w_rd_valid;
  logic [31:0]         w_rd_tag;
  logic [31:0]         w_rd_target;
  logic                w_hit;
  logic                w_pred_taken;
  logic                w_mispredict;
  logic [31:0]         w_pc_plus4;

  assign w_idx  = r_pc[IDX_BITS+1:2];
  assign w_ridx = resolve_pc[IDX_BITS+1:2];

  fetch_steer_ctrl_bp_table #(
    .IDX_BITS (IDX_BITS)
  ) u_bp_table (
    .clk         (clk),
    .rst         (reset),
    .i_rd_idx    (w_idx),
    .o_rd_ctr    (w_rd_ctr),
    .o_rd_valid  (w_rd_valid),
    .o_rd_tag    (w_rd_tag),
    .o_rd_target (w_rd_target),
    .i_wr_en     (resolve_valid),
    .i_wr_idx    (w_ridx),
    .i_wr_taken  (resolve_taken),
    .i_wr_tag    (resolve_pc),
    .i_wr_target (resolve_target)
  );

  // Full-pc tag avoids aliasing between branches sharing an index.
  assign w_hit        = w_rd_valid && (w_rd_tag == r_pc);
  assign w_pred_taken = w_hit && (w_rd_ctr >= C_CTR_WT);
  assign w_pc_plus4   = r_pc + 32'd4;

  // A wrong target only matters when the branch was actually taken.
  assign w_mispredict = resolve_valid &&
                        ((resolve_taken != resolve_pred_taken) ||
                         (resolve_taken && (resolve_pred_target != resolve_target)));

  assign pc             = r_pc;
  assign predict_taken  = w_pred_taken;
  assign predict_target = w_pred_taken ? w_rd_target : w_pc_plus4;
  assign flush          = w_mispredict;
  assign fetch_valid    = (r_state == ST_RUN) && !stall && (r_pc < PC_LIMIT);
  assign halted         = (r_state == ST_HALT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= RESET_PC;
      r_state <= ST_RUN;
    end else if (w_mispredict) begin
      // Redirect beats stall and works from any state.
      r_pc    <= resolve_taken ? resolve_target : resolve_pc + 32'd4;
      r_state <= ST_FLUSH;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (r_pc >= PC_LIMIT) begin
            r_state <= ST_HALT;
          end else if (!stall) begin
            r_pc <= w_pred_taken ? w_rd_target : w_pc_plus4;
          end
        end
        ST_FLUSH: r_state <= ST_RUN;
        ST_HALT:  r_state <= ST_HALT;
        default:  r_state <= ST_RUN;
      endcase
    end
  end

endmodule : fetch_steer_ctrl
`default_nettype wire

// File: tb/tb_fetch_steer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_steer_ctrl
// Description : Self-checking bench for fetch_steer_ctrl: directed run to
//               halt, halt recovery and reset-in-flush, a table of per-cycle
//               vectors, then randomized traffic against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_steer_ctrl;

  localparam logic [31:0] LIMIT = 32'd128;
  localparam logic        Y     = 1'b1;
  localparam logic        N     = 1'b0;
  localparam int          NV    = 22;
  localparam int          NRND  = 600;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [31:0] pc;
  logic        fetch_valid;
  logic        predict_taken;
  logic [31:0] predict_target;
  logic        resolve_valid;
  logic [31:0] resolve_pc;
  logic        resolve_taken;
  logic [31:0] resolve_target;
  logic        resolve_pred_taken;
  logic [31:0] resolve_pred_target;
  logic        flush;
  logic        halted;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  fetch_steer_ctrl #(
    .IDX_BITS (4),
    .PC_LIMIT (LIMIT),
    .RESET_PC (32'd0)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .stall               (stall),
    .pc                  (pc),
    .fetch_valid         (fetch_valid),
    .predict_taken       (predict_taken),
    .predict_target      (predict_target),
    .resolve_valid       (resolve_valid),
    .resolve_pc          (resolve_pc),
    .resolve_taken       (resolve_taken),
    .resolve_target      (resolve_target),
    .resolve_pred_taken  (resolve_pred_taken),
    .resolve_pred_target (resolve_pred_target),
    .flush               (flush),
    .halted              (halted)
  );

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  // Drives one cycle of inputs; also releases reset.
  task automatic drive(input logic s, input logic rv, input logic [31:0] rpc,
                       input logic rt, input logic [31:0] rtgt,
                       input logic rpt, input logic [31:0] rptgt);
    reset               = 1'b0;
    stall               = s;
    resolve_valid       = rv;
    resolve_pc          = rpc;
    resolve_taken       = rt;
    resolve_target      = rtgt;
    resolve_pred_taken  = rpt;
    resolve_pred_target = rptgt;
  endtask

  task automatic idle();
    drive(N, N, 32'h0, N, 32'h0, N, 32'h0);
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    logic        s;
    logic        rv;
    logic [31:0] rpc;
    logic        rt;
    logic [31:0] rtgt;
    logic        rpt;
    logic [31:0] rptgt;
    logic [31:0] e_pc;
    logic        e_fv;
    logic        e_pt;
    logic [31:0] e_ptgt;
    logic        e_flush;
    logic        e_halt;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(input logic s, input logic rv, input logic [31:0] rpc,
                              input logic rt, input logic [31:0] rtgt,
                              input logic rpt, input logic [31:0] rptgt,
                              input logic [31:0] e_pc, input logic e_fv, input logic e_pt,
                              input logic [31:0] e_ptgt, input logic e_flush,
                              input logic e_halt);
    vec_t v;
    v.s = s; v.rv = rv; v.rpc = rpc; v.rt = rt; v.rtgt = rtgt; v.rpt = rpt; v.rptgt = rptgt;
    v.e_pc = e_pc; v.e_fv = e_fv; v.e_pt = e_pt; v.e_ptgt = e_ptgt;
    v.e_flush = e_flush; v.e_halt = e_halt;
    return v;
  endfunction

  // ---------------- reference model ----------------
  int unsigned m_ctr [16];
  bit          m_bv  [16];
  logic [31:0] m_tag [16];
  logic [31:0] m_tgt [16];
  logic [31:0] m_pc;
  bit          m_halt;
  bit          m_bubble;

  task automatic model_reset();
    m_pc     = 32'h0;
    m_halt   = 1'b0;
    m_bubble = 1'b0;
    for (int i = 0; i < 16; i++) begin
      m_ctr[i] = 1;
      m_bv[i]  = 1'b0;
      m_tag[i] = 32'h0;
      m_tgt[i] = 32'h0;
    end
  endtask

  task automatic random_cycle(input int cyc);
    int unsigned ix;
    int unsigned ri;
    bit          e_pt;
    logic [31:0] e_ptgt;
    bit          e_fv;
    bit          mis;
    @(negedge clk);
    drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
          $urandom_range(0, 40) << 2, 1'($urandom_range(0, 1)),
          $urandom_range(0, 40) << 2, 1'($urandom_range(0, 1)), 32'h0);
    resolve_pred_target = ($urandom_range(0, 1) == 0) ? resolve_target
                                                      : ($urandom_range(0, 40) << 2);
    if ($urandom_range(0, 79) == 0) reset = 1'b1;
    #1;
    ix     = (m_pc / 4) % 16;
    e_pt   = m_bv[ix] && (m_tag[ix] == m_pc) && (m_ctr[ix] >= 2);
    e_ptgt = e_pt ? m_tgt[ix] : m_pc + 32'd4;
    e_fv   = !m_halt && !m_bubble && !stall && (m_pc < LIMIT);
    mis    = resolve_valid && ((resolve_taken != resolve_pred_taken) ||
                               (resolve_taken && (resolve_pred_target != resolve_target)));
    chk32($sformatf("rnd%0d pc", cyc), pc, m_pc);
    chk1($sformatf("rnd%0d fetch_valid", cyc), fetch_valid, e_fv);
    chk1($sformatf("rnd%0d predict_taken", cyc), predict_taken, e_pt);
    chk32($sformatf("rnd%0d predict_target", cyc), predict_target, e_ptgt);
    chk1($sformatf("rnd%0d flush", cyc), flush, mis);
    chk1($sformatf("rnd%0d halted", cyc), halted, m_halt);
    // advance the model across the coming clock edge
    if (reset) begin
      model_reset();
    end else begin
      if (resolve_valid) begin
        ri = (resolve_pc / 4) % 16;
        if (resolve_taken) begin
          if (m_ctr[ri] < 3) m_ctr[ri]++;
          m_bv[ri]  = 1'b1;
          m_tag[ri] = resolve_pc;
          m_tgt[ri] = resolve_target;
        end else if (m_ctr[ri] > 0) begin
          m_ctr[ri]--;
        end
      end
      if (mis) begin
        m_pc     = resolve_taken ? resolve_target : resolve_pc + 32'd4;
        m_bubble = 1'b1;
        m_halt   = 1'b0;
      end else if (m_bubble) begin
        m_bubble = 1'b0;
      end else if (!m_halt) begin
        if (m_pc >= LIMIT) m_halt = 1'b1;
        else if (!stall) m_pc = e_pt ? e_ptgt : m_pc + 32'd4;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, n_total=%0d", n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    // tests 2-5 as per-cycle vectors, starting right after a reset
    vecs[0]  = mk(N, N, 32'h00, N, 32'h00, N, 32'h00, 32'h00, Y, N, 32'h04, N, N);
    vecs[1]  = mk(N, N, 32'h00, N, 32'h00, N, 32'h00, 32'h04, Y, N, 32'h08, N, N);
    vecs[2]  = mk(N, Y, 32'h08, Y, 32'h20, N, 32'h00, 32'h08, Y, N, 32'h0C, Y, N);
    vecs[3]  = mk(N, N, 32'h00, N, 32'h00, N, 32'h00, 32'h20, N, N, 32'h24, N, N);
    vecs[4]  = mk(N, Y, 32'h04, N, 32'h00, Y, 32'h00, 32'h20, Y, N, 32'h24, Y, N);
    vecs[5]  = mk(N, N, 32'h00, N, 32'h00, N, 32'h00, 32'h08, N, Y, 32'h20, N, N);
    vecs[6]  = mk(N, N, 32'h00, N, 32'h00, N, 32'h00, 32'h08, Y, Y, 32'h20, N, N);
    vecs[7]  = mk(N, Y, 32'h08, N, 32'h00, N, 32'h00, 32'h20, Y, N, 32'h24, N, N);
    vecs[8]  = mk(N, Y, 32'h08, N, 32'h00, N, 32'h00, 32'h24, Y, N, 32'h28, N, N);
    vecs[9]  = mk(N, Y, 32'h08, N, 32'h00, N, 32'h00, 32'h28, Y, N, 32'h2C, N, N);
    vecs[10] = mk(N, Y, 32'h08, N, 32'h00, N, 32'h00, 32'h2C, Y, N, 32'h30, N, N);
    vecs[11] = mk(N, Y, 32'h04, N, 32'h00, Y, 32'h00, 32'h30, Y, N, 32'h34, Y, N);
    vecs[12] = mk(N, Y, 32'h08, Y, 32'h20, Y, 32'h20, 32'h08, N, N, 32'h0C, N, N);
    vecs[13] = mk(N, N, 32'h00, N, 32'h00, N, 32'h00, 32'h08, Y, N, 32'h0C, N, N);
    vecs[14] = mk(N, N, 32'h00, N, 32'h00, N, 32'h00, 32'h0C, Y, N, 32'h10, N, N);
    vecs[15] = mk(Y, N, 32'h00, N, 32'h00, N, 32'h00, 32'h10, N, N, 32'h14, N, N);
    vecs[16] = mk(Y, N, 32'h00, N, 32'h00, N, 32'h00, 32'h10, N, N, 32'h14, N, N);
    vecs[17] = mk(Y, N, 32'h00, N, 32'h00, N, 32'h00, 32'h10, N, N, 32'h14, N, N);
    vecs[18] = mk(Y, Y, 32'h04, N, 32'h00, Y, 32'h00, 32'h10, N, N, 32'h14, Y, N);
    vecs[19] = mk(N, N, 32'h00, N, 32'h00, N, 32'h00, 32'h08, N, N, 32'h0C, N, N);
    vecs[20] = mk(N, N, 32'h00, N, 32'h00, N, 32'h00, 32'h08, Y, N, 32'h0C, N, N);
    vecs[21] = mk(N, N, 32'h00, N, 32'h00, N, 32'h00, 32'h0C, Y, N, 32'h10, N, N);

    // ---- reset state ----
    idle();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk32("reset pc", pc, 32'h0);
    chk1("reset halted", halted, N);
    chk1("reset flush", flush, N);
    chk1("reset predict_taken", predict_taken, N);

    // ---- test 1: sequential fetch to the end of memory ----
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      idle();
      #1;
      chk32($sformatf("seq pc k=%0d", k), pc, 32'(k * 4));
      chk1($sformatf("seq fetch_valid k=%0d", k), fetch_valid, Y);
    end
    @(negedge clk); idle(); #1;
    chk32("limit pc", pc, 32'd128);
    chk1("limit fetch_valid", fetch_valid, N);
    chk1("limit halted", halted, N);
    @(negedge clk); idle(); #1;
    chk32("halt pc", pc, 32'd128);
    chk1("halt halted", halted, Y);
    chk1("halt fetch_valid", fetch_valid, N);

    // ---- test 6: leave HALT via mispredict, then reset during FLUSH ----
    @(negedge clk); drive(N, Y, 32'h40, Y, 32'h0, N, 32'h0); #1;
    chk1("halt redirect flush", flush, Y);
    chk1("halt redirect halted", halted, Y);
    @(negedge clk); idle(); #1;
    chk32("post-halt flush pc", pc, 32'h0);
    chk1("post-halt flush fetch_valid", fetch_valid, N);
    chk1("post-halt flush halted", halted, N);
    // not-taken resolve drives ctr[2] down to 00 ahead of the reset
    @(negedge clk); drive(N, Y, 32'h08, N, 32'h0, N, 32'h0); #1;
    chk32("post-halt run pc", pc, 32'h0);
    chk1("post-halt run fetch_valid", fetch_valid, Y);
    @(negedge clk); drive(N, Y, 32'h04, N, 32'h0, Y, 32'h0); #1;
    chk32("second redirect pc", pc, 32'h4);
    chk1("second redirect flush", flush, Y);
    @(negedge clk); idle(); reset = 1'b1; #1;
    chk32("in-flush pc", pc, 32'h8);
    chk1("in-flush fetch_valid", fetch_valid, N);

    // ---- tests 2-5: vector table directly after that reset ----
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].s, vecs[i].rv, vecs[i].rpc, vecs[i].rt, vecs[i].rtgt,
            vecs[i].rpt, vecs[i].rptgt);
      #1;
      chk32($sformatf("vec%0d pc", i), pc, vecs[i].e_pc);
      chk1($sformatf("vec%0d fetch_valid", i), fetch_valid, vecs[i].e_fv);
      chk1($sformatf("vec%0d predict_taken", i), predict_taken, vecs[i].e_pt);
      chk32($sformatf("vec%0d predict_target", i), predict_target, vecs[i].e_ptgt);
      chk1($sformatf("vec%0d flush", i), flush, vecs[i].e_flush);
      chk1($sformatf("vec%0d halted", i), halted, vecs[i].e_halt);
    end

    // ---- randomized traffic against the reference model ----
    @(negedge clk);
    idle();
    reset = 1'b1;
    model_reset();
    for (int c = 0; c < NRND; c++) begin
      random_cycle(c);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_fetch_steer_ctrl
`default_nettype wire
